// File: rtl/mips_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS datapath.
// Handles instruction-memory wait states, fetch timeout, HALT and a retired-instruction count.
module mips_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      instr_in,
    output logic             ir_load,
    output logic             pc_en,
    output logic             reg_write,
    output logic             alu_src,
    output logic             wb_sel,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SHIFT = 6'h01;
    localparam logic [5:0] OP_LDIMM = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             do_write_q, do_write_d;
    logic             alu_src_q, alu_src_d;
    logic             wb_sel_q, wb_sel_d;
    logic             illegal_q, illegal_d;
    logic             pc_en_q, pc_en_d;
    logic             reg_write_q, reg_write_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Only the opcode field is consumed here; the rest belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[25:0];

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        opcode_d    = opcode_q;
        do_write_d  = do_write_q;
        alu_src_d   = alu_src_q;
        wb_sel_d    = wb_sel_q;
        illegal_d   = illegal_q;
        count_d     = count_q;
        pc_en_d     = 1'b0;
        reg_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack arriving on the expiry cycle still wins over the timeout.
                if (imem_ack) begin
                    opcode_d = instr_in[31:26];
                    tmo_d    = 8'd0;
                    state_d  = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = 8'd0;
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode_q)
                    OP_RTYPE: begin
                        alu_src_d  = 1'b0;
                        wb_sel_d   = 1'b0;
                        do_write_d = 1'b1;
                    end
                    OP_SHIFT: begin
                        alu_src_d  = 1'b1;
                        wb_sel_d   = 1'b0;
                        do_write_d = 1'b1;
                    end
                    OP_LDIMM: begin
                        alu_src_d  = 1'b0;
                        wb_sel_d   = 1'b1;
                        do_write_d = 1'b1;
                    end
                    OP_HALT: begin
                        do_write_d = 1'b0;
                        state_d    = S_HALT;
                    end
                    default: begin
                        illegal_d  = 1'b1;
                        do_write_d = 1'b0;
                    end
                endcase
            end
            S_EXEC: begin
                // Strobes are registered, so they are raised for the WB cycle here.
                state_d     = S_WB;
                pc_en_d     = 1'b1;
                reg_write_d = do_write_q;
            end
            S_WB: begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC)  || (state_d == S_WB);
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmo_q       <= 8'd0;
            opcode_q    <= 6'd0;
            do_write_q  <= 1'b0;
            alu_src_q   <= 1'b0;
            wb_sel_q    <= 1'b0;
            illegal_q   <= 1'b0;
            pc_en_q     <= 1'b0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            opcode_q    <= opcode_d;
            do_write_q  <= do_write_d;
            alu_src_q   <= alu_src_d;
            wb_sel_q    <= wb_sel_d;
            illegal_q   <= illegal_d;
            pc_en_q     <= pc_en_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign ir_load     = imem_req & imem_ack;
    assign pc_en       = pc_en_q;
    assign reg_write   = reg_write_q;
    assign alu_src     = alu_src_q;
    assign wb_sel      = wb_sel_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
